// File: rtl/exec_pkg.sv
// Shared types for the execute stage: ALU op encodings, FSM states and the control bundle.
// The multiply FSM types are only consumed when EXEC_MUL_EN is defined.
package exec_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SHL = 3'b101,
        ALU_SHR = 3'b110,
        ALU_MUL = 3'b111
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic       wbs;
        logic       wme;
        logic [1:0] mm;
        logic       wm;
        logic       am;
        logic       ni;
    } ctrl_t;

    function automatic ctrl_t bubble_ctrl();
        ctrl_t c;
        c = '0;
        c.ni = 1'b1;
        return c;
    endfunction

    // MUL is not handled here; it yields 0 so the single-cycle build can reuse this directly.
    function automatic logic [DATA_W-1:0] alu_single(input alu_op_e op,
                                                     input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        r = '0;
        case (op)
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_SHL: r = a << b[3:0];
            ALU_SHR: r = a >> b[3:0];
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/execute_stage_mul.sv
// mul_iter16: 16-step shift-add multiplier (low DATA_W bits of the product).
// Built only when EXEC_MUL_EN is defined.
`ifdef EXEC_MUL_EN
module mul_iter16 #(
    parameter int W     = exec_pkg::DATA_W,
    parameter int STEPS = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         step,
    input  logic         clear,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic [W-1:0] product_out,
    output logic         done_out
);
    localparam int CW = $clog2(STEPS);

    logic [W-1:0]  mcand_q, mcand_d;
    logic [W-1:0]  mplier_q, mplier_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  acc_step;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    // The accumulator after the current step, so the final product is usable on the last edge.
    always_comb begin
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (start) begin
            mcand_d  = a_in;
            mplier_d = b_in;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (step) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
        end
    end

    assign product_out = acc_step;
    assign done_out    = (cnt_q == CW'(STEPS - 1));

endmodule
`endif

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU plus optional 16-cycle iterative MUL (macro EXEC_MUL_EN).
// Without EXEC_MUL_EN, ALUop 111 returns 0 in one cycle and stall_out is tied low.
module execute_stage #(
    parameter int DATA_W     = 16,
    parameter int MUL_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wbs_in,
    input  logic              wme_in,
    input  logic              wm_in,
    input  logic              am_in,
    input  logic              ni_in,
    input  logic [1:0]        mm_in,
    input  logic [2:0]        ALUop_in,
    input  logic [DATA_W-1:0] srcA_in,
    input  logic [DATA_W-1:0] srcB_in,
    input  logic              flush_in,
    output logic              stall_out,
    output logic              wbs_out,
    output logic              wme_out,
    output logic              wm_out,
    output logic              am_out,
    output logic              ni_out,
    output logic [1:0]        mm_out,
    output logic [DATA_W-1:0] result_out,
    output logic              zero_out,
    output logic              neg_out
);
    import exec_pkg::*;

    if (DATA_W != 16 || MUL_CYCLES != DATA_W) begin : g_cfg_check
        $error("execute_stage supports only DATA_W = MUL_CYCLES = 16");
    end

    ctrl_t             ctrl_in;
    logic [DATA_W-1:0] alu_res;
    logic              is_mul;

    ctrl_t             ctrl_q, ctrl_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic              neg_q, neg_d;
    logic              out_valid;

    assign ctrl_in = '{wbs: wbs_in, wme: wme_in, mm: mm_in, wm: wm_in, am: am_in, ni: ni_in};
    assign is_mul  = (alu_op_e'(ALUop_in) == ALU_MUL);

    always_comb begin
        alu_res = alu_single(alu_op_e'(ALUop_in), srcA_in, srcB_in);
    end

`ifdef EXEC_MUL_EN
    // state   | meaning
    // IDLE    | accepting ops; single-cycle results or MUL start
    // BUSY    | shift-add in progress; live inputs ignored
    state_e            state_q, state_d;
    ctrl_t             mul_ctrl_q, mul_ctrl_d;
    logic              mul_start, mul_step, mul_done;
    logic [DATA_W-1:0] mul_prod;

    assign mul_start = (state_q == ST_IDLE) && is_mul && !ni_in && !flush_in;
    assign mul_step  = (state_q == ST_BUSY) && !flush_in;

    mul_iter16 #(.W(DATA_W), .STEPS(MUL_CYCLES)) u_mul (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (mul_start),
        .step        (mul_step),
        .clear       (flush_in),
        .a_in        (srcA_in),
        .b_in        (srcB_in),
        .product_out (mul_prod),
        .done_out    (mul_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mul_ctrl_q <= bubble_ctrl();
        end else begin
            state_q    <= state_d;
            mul_ctrl_q <= mul_ctrl_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mul_ctrl_d = mul_ctrl_q;
        if (flush_in) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mul_start) begin
                        state_d    = ST_BUSY;
                        mul_ctrl_d = ctrl_in;
                    end
                end
                ST_BUSY: begin
                    if (mul_done) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        stall_out = 1'b0;
        ctrl_d    = bubble_ctrl();
        result_d  = '0;
        out_valid = 1'b0;
        if (!flush_in) begin
            case (state_q)
                ST_IDLE: begin
                    stall_out = is_mul && !ni_in;
                    if (!ni_in && !is_mul) begin
                        ctrl_d    = ctrl_in;
                        result_d  = alu_res;
                        out_valid = 1'b1;
                    end
                end
                ST_BUSY: begin
                    stall_out = !mul_done;
                    if (mul_done) begin
                        ctrl_d    = mul_ctrl_q;
                        result_d  = mul_prod;
                        out_valid = 1'b1;
                    end
                end
                default: stall_out = 1'b0;
            endcase
        end
    end
`else
    always_comb begin
        stall_out = 1'b0;
        ctrl_d    = bubble_ctrl();
        result_d  = '0;
        out_valid = 1'b0;
        if (!flush_in && !ni_in) begin
            ctrl_d    = ctrl_in;
            result_d  = alu_res;
            out_valid = 1'b1;
        end
    end
`endif

    // Bubbles carry zero flags even though their result is 0.
    always_comb begin
        zero_d = out_valid && (result_d == '0);
        neg_d  = out_valid && result_d[DATA_W-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q   <= bubble_ctrl();
            result_q <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
        end
    end

    assign wbs_out    = ctrl_q.wbs;
    assign wme_out    = ctrl_q.wme;
    assign wm_out     = ctrl_q.wm;
    assign am_out     = ctrl_q.am;
    assign ni_out     = ctrl_q.ni;
    assign mm_out     = ctrl_q.mm;
    assign result_out = result_q;
    assign zero_out   = zero_q;
    assign neg_out    = neg_q;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage; the reference model tracks a remaining-cycle count
// for an in-flight multiply and computes results with plain integer arithmetic.
module tb_execute_stage;

`ifdef EXEC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wbs_in, wme_in, wm_in, am_in, ni_in;
    logic [1:0]  mm_in;
    logic [2:0]  ALUop_in;
    logic [15:0] srcA_in, srcB_in;
    logic        flush_in;
    logic        stall_out;
    logic        wbs_out, wme_out, wm_out, am_out, ni_out;
    logic [1:0]  mm_out;
    logic [15:0] result_out;
    logic        zero_out, neg_out;

    always #5 clk = ~clk;

    execute_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wbs_in     (wbs_in),
        .wme_in     (wme_in),
        .wm_in      (wm_in),
        .am_in      (am_in),
        .ni_in      (ni_in),
        .mm_in      (mm_in),
        .ALUop_in   (ALUop_in),
        .srcA_in    (srcA_in),
        .srcB_in    (srcB_in),
        .flush_in   (flush_in),
        .stall_out  (stall_out),
        .wbs_out    (wbs_out),
        .wme_out    (wme_out),
        .wm_out     (wm_out),
        .am_out     (am_out),
        .ni_out     (ni_out),
        .mm_out     (mm_out),
        .result_out (result_out),
        .zero_out   (zero_out),
        .neg_out    (neg_out)
    );

    int checks = 0;
    int errors = 0;
    int stall_hi = 0;
    bit last_stall = 1'b0;

    // Reference model state: an in-flight multiply is just "cycles left" plus its answer.
    bit          m_busy;
    int          m_left;
    logic [15:0] m_prod;
    logic        m_wbs, m_wme, m_wm, m_am;
    logic [1:0]  m_mm;

    logic        e_ni, e_wbs, e_wme, e_wm, e_am, e_zero, e_neg, e_full, e_stall;
    logic [1:0]  e_mm;
    logic [15:0] e_res;

    function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
        longint ia, ib, r;
        ia = longint'(a);
        ib = longint'(b);
        case (op)
            3'd0:    r = (ia + ib) % 65536;
            3'd1:    r = (ia - ib + 65536) % 65536;
            3'd2:    r = longint'(a & b);
            3'd3:    r = longint'(a | b);
            3'd4:    r = longint'(a ^ b);
            3'd5:    r = (ia * (64'sd1 << (ib % 16))) % 65536;
            3'd6:    r = ia / (64'sd1 << (ib % 16));
            default: r = MUL_EN ? (ia * ib) % 65536 : 0;
        endcase
        return 16'(r);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_bubble_exp();
        e_ni = 1'b1; e_wbs = 1'b0; e_wme = 1'b0; e_wm = 1'b0; e_am = 1'b0; e_mm = 2'b00;
        e_res = 16'h0; e_zero = 1'b0; e_neg = 1'b0; e_full = 1'b0;
    endtask

    task automatic set_result_exp(input logic [15:0] r);
        e_res = r; e_zero = (r == 16'h0); e_neg = r[15]; e_ni = 1'b0; e_full = 1'b1;
    endtask

    // One clock cycle: check combinational stall, advance the model, check registered outputs.
    task automatic step();
        #1;
        if (flush_in)    e_stall = 1'b0;
        else if (m_busy) e_stall = (m_left != 1);
        else             e_stall = MUL_EN && (ALUop_in == 3'd7) && !ni_in;
        chk("stall", 16'(stall_out), 16'(e_stall));
        last_stall = stall_out;
        if (stall_out === 1'b1) stall_hi++;

        if (!rst_n) begin
            set_bubble_exp();
            e_full = 1'b1;
            m_busy = 1'b0;
        end else if (flush_in) begin
            set_bubble_exp();
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (m_left == 1) begin
                set_result_exp(m_prod);
                e_wbs = m_wbs; e_wme = m_wme; e_wm = m_wm; e_am = m_am; e_mm = m_mm;
                m_busy = 1'b0;
            end else begin
                set_bubble_exp();
                m_left--;
            end
        end else if (ni_in) begin
            set_bubble_exp();
        end else if (MUL_EN && ALUop_in == 3'd7) begin
            set_bubble_exp();
            m_busy = 1'b1;
            m_left = 16;
            m_prod = ref_alu(3'd7, srcA_in, srcB_in);
            m_wbs = wbs_in; m_wme = wme_in; m_wm = wm_in; m_am = am_in; m_mm = mm_in;
        end else begin
            set_result_exp(ref_alu(ALUop_in, srcA_in, srcB_in));
            e_wbs = wbs_in; e_wme = wme_in; e_wm = wm_in; e_am = am_in; e_mm = mm_in;
        end

        @(posedge clk);
        #1;
        chk("ni_out", 16'(ni_out), 16'(e_ni));
        chk("wbs_out", 16'(wbs_out), 16'(e_wbs));
        chk("wme_out", 16'(wme_out), 16'(e_wme));
        chk("wm_out", 16'(wm_out), 16'(e_wm));
        chk("result_out", result_out, e_res);
        chk("zero_out", 16'(zero_out), 16'(e_zero));
        chk("neg_out", 16'(neg_out), 16'(e_neg));
        if (e_full) begin
            chk("mm_out", 16'(mm_out), 16'(e_mm));
            chk("am_out", 16'(am_out), 16'(e_am));
        end
    endtask

    task automatic set_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic wbs, input logic [1:0] mm);
        ALUop_in = op; srcA_in = a; srcB_in = b;
        wbs_in = wbs; mm_in = mm; wme_in = 1'b0; wm_in = 1'b1; am_in = 1'b0;
        ni_in = 1'b0; flush_in = 1'b0;
    endtask

    // Upstream holds the MUL on its register until stall drops, so present it for 17 cycles.
    task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] expect_prod);
        set_op(3'd7, a, b, 1'b1, 2'b10);
        stall_hi = 0;
        repeat (17) step();
        chk("mul_product", result_out, MUL_EN ? expect_prod : 16'h0000);
        chk("mul_stall_cycles", 16'(stall_hi), MUL_EN ? 16'd16 : 16'd0);
    endtask

    initial begin
        m_busy = 1'b0; m_left = 0; m_prod = '0;
        m_wbs = 0; m_wme = 0; m_wm = 0; m_am = 0; m_mm = '0;
        rst_n = 1'b0;
        set_op(3'd0, 16'h1111, 16'h2222, 1'b1, 2'b11);
        @(posedge clk);
        #1;
        step();

        rst_n = 1'b1;
        set_op(3'd0, 16'h7FFF, 16'h0001, 1'b1, 2'b10);
        step();
        chk("add_result", result_out, 16'h8000);
        set_op(3'd1, 16'h0005, 16'h0005, 1'b0, 2'b01);
        step();
        chk("sub_zero", 16'(zero_out), 16'd1);
        set_op(3'd5, 16'h0001, 16'h0013, 1'b1, 2'b00);
        step();
        chk("shl_result", result_out, 16'h0008);
        set_op(3'd6, 16'h8000, 16'h0004, 1'b1, 2'b00);
        step();

        run_mul(16'h0003, 16'h0005, 16'h000F);
        chk("mul_wbs", 16'(wbs_out), 16'd1);
        chk("mul_mm", 16'(mm_out), 16'd2);
        run_mul(16'h1234, 16'h0100, 16'h3400);
        run_mul(16'h0003, 16'h0005, 16'h000F);

        set_op(3'd7, 16'h0007, 16'h0009, 1'b1, 2'b01);
        repeat (5) step();
        flush_in = 1'b1;
        step();
        set_op(3'd0, 16'h0001, 16'h0002, 1'b0, 2'b00);
        repeat (20) step();

        set_op(3'd7, 16'h0004, 16'h0004, 1'b1, 2'b11);
        ni_in = 1'b1;
        step();

        set_op(3'd7, 16'h00FF, 16'h00FF, 1'b1, 2'b11);
        repeat (8) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        set_op(3'd0, 16'h0100, 16'h0023, 1'b1, 2'b01);
        step();
        chk("add_after_reset", result_out, 16'h0123);
        step();

        for (int i = 0; i < 400; i++) begin
            if (!last_stall) begin
                ALUop_in = ($urandom_range(0, 3) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
                srcA_in  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
                srcB_in  = 16'($urandom);
                ni_in    = ($urandom_range(0, 6) == 0);
                wbs_in   = 1'($urandom);
                wme_in   = 1'($urandom);
                wm_in    = 1'($urandom);
                am_in    = 1'($urandom);
                mm_in    = 2'($urandom);
            end
            flush_in = ($urandom_range(0, 24) == 0);
            rst_n    = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
